// File: rtl/mconst_pkg.sv
// Shared definitions for the multi-beat constant assembler: FSM encoding,
// beat mode constants and default widths.
package mconst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_OUT     = 2'd2
  } mconst_state_e;

  localparam logic MODE_ZEXT = 1'b0;
  localparam logic MODE_PAIR = 1'b1;

  localparam int IMM_W_DEF = 16;
  localparam int OUT_W_DEF = 32;

endpackage

// File: rtl/mconst_zext.sv
// Zero-extends one immediate beat to the full result width.
module mconst_zext
  import mconst_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IMM_W-1:0] imm,
  output logic [OUT_W-1:0] ext
);

  assign ext = {{(OUT_W-IMM_W){1'b0}}, imm};

endmodule

// File: rtl/mconst_ctrl.sv
// Two-requester constant assembler: round-robin first-beat arbitration,
// single-beat zero-extend or two-beat low/high pairing, held result handshake.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no result pending; arbitrate a first beat from either port
// ST_WAIT_HI | low half captured; only the owning port may send the high beat
// ST_OUT     | result valid and held until the consumer accepts it
module mconst_ctrl
  import mconst_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  input  logic [IMM_W-1:0] req_imm0,
  input  logic [IMM_W-1:0] req_imm1,
  input  logic             req_mode0,
  input  logic             req_mode1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_src,
  output logic [7:0]       done_count
);

  if (OUT_W != 2*IMM_W) begin : g_bad_width
    $error("mconst_ctrl: OUT_W must equal 2*IMM_W");
  end

  mconst_state_e    state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [IMM_W-1:0] lo_q, lo_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_src_q, out_src_d;
  logic [7:0]       done_q, done_d;

  logic             sel_idx;
  logic [IMM_W-1:0] imm_sel;
  logic             mode_sel;
  logic [OUT_W-1:0] zext_val;
  logic [1:0]       grant;

  // rr_q holds the last first-beat winner; the other port wins a tie.
  always_comb begin
    sel_idx = owner_q;
    if (state_q == ST_IDLE) begin
      sel_idx = (&req_valid) ? ~rr_q : req_valid[1];
    end
    imm_sel  = sel_idx ? req_imm1 : req_imm0;
    mode_sel = sel_idx ? req_mode1 : req_mode0;
  end

  mconst_zext #(
    .IMM_W (IMM_W),
    .OUT_W (OUT_W)
  ) u_zext (
    .imm (imm_sel),
    .ext (zext_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b1;
      owner_q   <= 1'b0;
      lo_q      <= '0;
      out_q     <= '0;
      out_src_q <= 1'b0;
      done_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      lo_q      <= lo_d;
      out_q     <= out_d;
      out_src_q <= out_src_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    lo_d      = lo_q;
    out_d     = out_q;
    out_src_d = out_src_q;
    done_d    = done_q;
    grant     = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant[sel_idx] = 1'b1;
          rr_d           = sel_idx;
          if (mode_sel == MODE_PAIR) begin
            lo_d    = imm_sel;
            owner_d = sel_idx;
            state_d = ST_WAIT_HI;
          end else begin
            out_d     = zext_val;
            out_src_d = sel_idx;
            state_d   = ST_OUT;
          end
        end
      end
      ST_WAIT_HI: begin
        if (req_valid[owner_q]) begin
          grant[owner_q] = 1'b1;
          out_d          = {imm_sel, lo_q};
          out_src_d      = owner_q;
          state_d        = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          done_d  = done_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = reset_n ? grant : 2'b00;
    out_valid  = (state_q == ST_OUT);
    out        = out_q;
    out_src    = out_src_q;
    done_count = done_q;
  end

endmodule

// File: tb/tb_mconst_ctrl.sv
// Bench for mconst_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level model of the two-port constant assembler.
module tb_mconst_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [15:0] req_imm0, req_imm1;
  logic        req_mode0, req_mode1;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        out_src;
  logic [7:0]  done_count;

  int n_checks = 0;
  int n_errors = 0;

  // model: result-held flag, pending-pair flag and owner, last first-beat winner
  bit          m_res;
  bit          m_pair;
  bit          m_owner;
  bit          m_last;
  logic [15:0] m_low;
  logic [31:0] m_out;
  bit          m_src;
  logic [7:0]  m_cnt;

  mconst_ctrl #(.IMM_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_imm0   (req_imm0),
    .req_imm1   (req_imm1),
    .req_mode0  (req_mode0),
    .req_mode1  (req_mode1),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_src    (out_src),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_res = 0; m_pair = 0; m_owner = 0; m_last = 1;
    m_low = '0; m_out = '0; m_src = 0; m_cnt = '0;
  endtask

  // Called at a negedge; leaves at the next negedge.
  task automatic step(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1,
                      input logic md0, input logic md1, input logic ordy);
    logic [1:0]  er;
    bit          g;
    logic [15:0] gi;
    bit          gm;
    bit          n_res, n_pair, n_owner, n_last, n_src;
    logic [15:0] n_low;
    logic [31:0] n_out;
    logic [7:0]  n_cnt;
    req_valid = v; req_imm0 = i0; req_imm1 = i1;
    req_mode0 = md0; req_mode1 = md1; out_ready = ordy;
    er = 2'b00;
    n_res = m_res; n_pair = m_pair; n_owner = m_owner; n_last = m_last;
    n_src = m_src; n_low = m_low; n_out = m_out; n_cnt = m_cnt;
    if (m_res) begin
      if (ordy) begin
        n_res = 0;
        n_cnt = m_cnt + 8'd1;
      end
    end else if (m_pair) begin
      if (v[m_owner]) begin
        er[m_owner] = 1'b1;
        n_out  = {(m_owner ? i1 : i0), m_low};
        n_src  = m_owner;
        n_pair = 0;
        n_res  = 1;
      end
    end else if (v != 2'b00) begin
      g  = (v == 2'b11) ? !m_last : v[1];
      gi = g ? i1 : i0;
      gm = g ? md1 : md0;
      er[g]  = 1'b1;
      n_last = g;
      if (gm) begin
        n_low   = gi;
        n_owner = g;
        n_pair  = 1;
      end else begin
        n_out = {16'h0000, gi};
        n_src = g;
        n_res = 1;
      end
    end
    #1;
    chk("req_ready", {30'd0, req_ready}, {30'd0, er});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_res});
    chk("out", out, m_out);
    chk("out_src", {31'd0, out_src}, {31'd0, m_src});
    chk("done_count", {24'd0, done_count}, {24'd0, m_cnt});
    @(posedge clk);
    m_res = n_res; m_pair = n_pair; m_owner = n_owner; m_last = n_last;
    m_src = n_src; m_low = n_low; m_out = n_out; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  // Asserts reset with both requesters valid, checks forced values, releases.
  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    model_reset();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
    chk("rst_done_count", {24'd0, done_count}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    out_ready = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    reset_n = 1'b1;
    req_valid = 2'b00; req_imm0 = '0; req_imm1 = '0;
    req_mode0 = 1'b0; req_mode1 = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // req0 zero-extend
    step(2'b01, 16'h2F12, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("zext_out", out, 32'h0000_2F12);
    chk("zext_valid", {31'd0, out_valid}, 32'd1);
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("zext_done", {24'd0, done_count}, 32'd1);

    // req1 pair: low then high
    step(2'b10, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0);
    step(2'b10, 16'h0000, 16'h9618, 1'b0, 1'b0, 1'b0);
    chk("pair_out", out, 32'h9618_1234);
    chk("pair_src", {31'd0, out_src}, 32'd1);
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    // contention from reset alternates grants
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      step(2'b11, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
      chk("rr_src", {31'd0, out_src}, r % 2);
      chk("rr_out", out, (r % 2) ? 32'h2 : 32'h1);
      step(2'b11, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    end

    // req0 owns pair; req1 waits until result consumed
    step(2'b01, 16'hA5C3, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b0);
      chk("stall_req1", {30'd0, req_ready}, 32'd0);
    end
    step(2'b11, 16'hFFFF, 16'h7777, 1'b1, 1'b0, 1'b0);
    chk("owner_hi_out", out, 32'hFFFF_A5C3);
    step(2'b10, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b1);
    step(2'b10, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b0);
    chk("req1_after", out, 32'h0000_7777);

    // hold in OUT for 5 cycles
    held = out;
    for (int k = 0; k < 5; k++) begin
      step(2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      chk("hold_out", out, held);
    end
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    // reset in WAIT_HI discards partial result
    step(2'b01, 16'hBEEF, 16'h0, 1'b1, 1'b0, 1'b0);
    apply_reset();
    step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

    // 256 deliveries wrap done_count
    for (int k = 0; k < 256; k++) begin
      step(2'b01, k[15:0], 16'h0, 1'b0, 1'b0, 1'b0);
      step(2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (k == 254) chk("cnt_255", {24'd0, done_count}, 32'd255);
    end
    chk("cnt_wrap", {24'd0, done_count}, 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      step(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
